// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, state encoding and word helpers for the
// SHA-256 message padder.
//   BLK_W / WORD_W : chunk and word widths
//   PAD_BYTE       : the 0x80 terminator byte
//   state_e        : padder FSM states
//   bswap32        : byte reversal for little-endian sources
//   pad_word       : keep the first n bytes of a word, put 0x80 at byte n
package sha256_pkg;

  localparam int         BLK_W    = 512;
  localparam int         WORD_W   = 32;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {FILL, PAD, EMIT, LEN} state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // n is already clamped to 0..4; byte 0 is bits [31:24].
  function automatic logic [31:0] pad_word(input logic [31:0] data, input logic [2:0] n);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(n))       r[31-8*b -: 8] = data[31-8*b -: 8];
      else if (b == int'(n)) r[31-8*b -: 8] = PAD_BYTE;
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: applies SHA-256 padding (0x80, zero fill, 64-bit bit
// length) to a stream of 32-bit big-endian words and emits 512-bit chunks.
//
// Ports:
//   clock, reset           : rising-edge clock, async active-high reset
//   in_valid/in_ready      : word handshake
//   in_data, in_last       : message word, final-word marker
//   in_nbytes              : valid bytes in the final word (>4 means 4)
//   blk_valid/blk_ready    : chunk handshake
//   blk_data, blk_last     : chunk (word 0 in [511:480]), final-chunk marker
//
// Build option: define SHA_PAD_BYTESWAP_EN to byte-reverse each word on
// capture (little-endian source). Chunk layout is unchanged either way.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic [2:0]       in_nbytes,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_last
);

  state_e                state_q, state_d;
  logic [15:0][31:0]     buf_q, buf_d;
  logic [3:0]            idx_q, idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  // Word index that holds (or must receive) the 0x80 byte; 16 means it
  // did not fit and goes to word 0 of the extra chunk.
  logic [4:0]            pad_pos_q, pad_pos_d;
  logic                  pend_q, pend_d;   // 0x80 word not yet written
  logic                  extra_q, extra_d; // length needs a second chunk
  logic                  last_q, last_d;

  logic [31:0] cap_w;
  logic [2:0]  n;
  logic [63:0] len64;

`ifdef SHA_PAD_BYTESWAP_EN
  assign cap_w = bswap32(in_data);
`else
  assign cap_w = in_data;
`endif

  assign n     = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign len64 = 64'(len_q);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    len_d     = len_q;
    pad_pos_d = pad_pos_q;
    pend_d    = pend_q;
    extra_d   = extra_q;
    last_d    = last_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          if (!in_last) begin
            buf_d[idx_q] = cap_w;
            len_d        = len_q + LEN_W'(32);
            idx_d        = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_d = EMIT;
              last_d  = 1'b0;
            end
          end else begin
            len_d = len_q + LEN_W'({n, 3'b000});
            if (n != 3'd0) buf_d[idx_q] = pad_word(cap_w, n);
            // A full last word (n=4) or an empty one (n=0) leaves the
            // 0x80 to be written as a separate word in PAD.
            pend_d    = (n == 3'd0) || (n == 3'd4);
            pad_pos_d = (n == 3'd4) ? {1'b0, idx_q} + 5'd1 : {1'b0, idx_q};
            state_d   = PAD;
          end
        end
      end
      PAD: begin
        if (pend_q && !pad_pos_q[4]) begin
          buf_d[pad_pos_q[3:0]] = 32'h8000_0000;
          pend_d                = 1'b0;
        end
        if (pad_pos_q <= 5'd13) begin
          buf_d[14] = len64[63:32];
          buf_d[15] = len64[31:0];
          last_d    = 1'b1;
        end else begin
          extra_d = 1'b1;
          last_d  = 1'b0;
        end
        state_d = EMIT;
      end
      EMIT: begin
        if (blk_ready) begin
          buf_d  = '0;
          idx_d  = 4'd0;
          last_d = 1'b0;
          if (extra_q) begin
            extra_d = 1'b0;
            state_d = LEN;
          end else begin
            if (last_q) len_d = '0;
            state_d = FILL;
          end
        end
      end
      LEN: begin
        if (pend_q) begin
          buf_d[0] = 32'h8000_0000;
          pend_d   = 1'b0;
        end
        buf_d[14] = len64[63:32];
        buf_d[15] = len64[31:0];
        last_d    = 1'b1;
        state_d   = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      buf_q     <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      pad_pos_q <= '0;
      pend_q    <= 1'b0;
      extra_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      pad_pos_q <= pad_pos_d;
      pend_q    <= pend_d;
      extra_q   <= extra_d;
      last_q    <= last_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = buf_q;
  assign blk_last  = last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: short, empty, 56-byte and 64-byte
// messages, output backpressure and reset in the middle of a message.
module tb_sha256_msg_padder;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  int checks = 0;
  int errors = 0;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present one word and hold it until accepted; returns 1ns after the
  // accepting edge.
  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int ok;
    in_data = d; in_last = last; in_nbytes = nb; in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_nbytes = 3'd0;
  endtask

  // Wait for a chunk (lat = negedges waited), capture it, then accept it.
  task automatic wait_chunk(output logic [511:0] d, output logic l, output int lat);
    int ok;
    lat = 0; ok = 0; d = '0; l = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      lat++;
      if (blk_valid) begin ok = 1; break; end
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL chunk_timeout blk_valid=%0b required=1", blk_valid);
    end
    d = blk_data; l = blk_last;
    blk_ready = 1'b1;
    @(posedge clock);
    #1;
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid got=%0b exp=0", blk_valid); end
    if (blk_last !== 1'b0) begin errors++; $display("FAIL reset_blk_last got=%0b exp=0", blk_last); end
    if (blk_data !== 512'd0) begin errors++; $display("FAIL reset_blk_data got=%h exp=0", blk_data); end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_abc();
    logic [15:0][31:0] exp;
    logic [511:0] got;
    logic         l;
    int           lat;
    exp = '0;
    exp[0]  = 32'h6162_6380;
    exp[15] = 32'h0000_0018;
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_chunk(got, l, lat);
    checks += 3;
    if (got !== exp) begin errors++; $display("FAIL abc_data got=%h exp=%h", got, exp); end
    if (l !== 1'b1) begin errors++; $display("FAIL abc_last got=%0b exp=1", l); end
    if (lat != 2) begin errors++; $display("FAIL abc_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_empty();
    logic [15:0][31:0] exp;
    logic [511:0] got;
    logic         l;
    int           lat;
    exp = '0;
    exp[0] = 32'h8000_0000;
    send(32'hDEAD_BEEF, 1'b1, 3'd0);
    wait_chunk(got, l, lat);
    checks += 3;
    if (got !== exp) begin errors++; $display("FAIL empty_data got=%h exp=%h", got, exp); end
    if (l !== 1'b1) begin errors++; $display("FAIL empty_last got=%0b exp=1", l); end
    if (lat != 2) begin errors++; $display("FAIL empty_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_56_bytes();
    logic [15:0][31:0] exp1, exp2;
    logic [511:0] got;
    logic         l;
    int           lat;
    exp1 = '0; exp2 = '0;
    for (int i = 0; i < 14; i++) begin
      exp1[i] = 32'hA000_0000 + 32'(i);
      send(32'hA000_0000 + 32'(i), (i == 13), 3'd4);
    end
    exp1[14] = 32'h8000_0000;
    exp2[15] = 32'h0000_01C0;
    wait_chunk(got, l, lat);
    checks += 2;
    if (got !== exp1) begin errors++; $display("FAIL b56_chunk1 got=%h exp=%h", got, exp1); end
    if (l !== 1'b0) begin errors++; $display("FAIL b56_last1 got=%0b exp=0", l); end
    wait_chunk(got, l, lat);
    checks += 2;
    if (got !== exp2) begin errors++; $display("FAIL b56_chunk2 got=%h exp=%h", got, exp2); end
    if (l !== 1'b1) begin errors++; $display("FAIL b56_last2 got=%0b exp=1", l); end
  endtask

  task automatic test_64_bytes();
    logic [15:0][31:0] exp1, exp2;
    logic [511:0] got;
    logic         l;
    int           lat;
    exp1 = '0; exp2 = '0;
    for (int i = 0; i < 16; i++) begin
      exp1[i] = 32'hB000_0100 + 32'(i);
      send(32'hB000_0100 + 32'(i), (i == 15), 3'd4);
    end
    exp2[0]  = 32'h8000_0000;
    exp2[15] = 32'h0000_0200;
    wait_chunk(got, l, lat);
    checks += 2;
    if (got !== exp1) begin errors++; $display("FAIL b64_chunk1 got=%h exp=%h", got, exp1); end
    if (l !== 1'b0) begin errors++; $display("FAIL b64_last1 got=%0b exp=0", l); end
    wait_chunk(got, l, lat);
    checks += 2;
    if (got !== exp2) begin errors++; $display("FAIL b64_chunk2 got=%h exp=%h", got, exp2); end
    if (l !== 1'b1) begin errors++; $display("FAIL b64_last2 got=%0b exp=1", l); end
  endtask

  task automatic test_backpressure();
    logic [15:0][31:0] exp1, exp2;
    logic [511:0] got;
    logic         l;
    int           lat;
    exp1 = '0; exp2 = '0;
    for (int i = 0; i < 16; i++) begin
      exp1[i] = 32'hC000_0000 + 32'(i);
      send(32'hC000_0000 + 32'(i), 1'b0, 3'd0);
    end
    // Hold the final word on the input while the chunk is stalled; it must
    // not be taken until the chunk is accepted.
    in_data = 32'h1234_5678; in_last = 1'b1; in_nbytes = 3'd4; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks += 4;
      if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%0b exp=1", c, blk_valid); end
      if (blk_data !== exp1) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, blk_data, exp1); end
      if (blk_last !== 1'b0) begin errors++; $display("FAIL bp_last cyc=%0d got=%0b exp=0", c, blk_last); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", c, in_ready); end
    end
    blk_ready = 1'b1;
    @(posedge clock);
    #1;
    blk_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%0b exp=1", in_ready); end
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_nbytes = 3'd0;
    // 17 words = 544 bits; held word lands once at word 0.
    exp2[0]  = 32'h1234_5678;
    exp2[1]  = 32'h8000_0000;
    exp2[15] = 32'h0000_0220;
    wait_chunk(got, l, lat);
    checks += 3;
    if (got !== exp2) begin errors++; $display("FAIL bp_chunk2 got=%h exp=%h", got, exp2); end
    if (l !== 1'b1) begin errors++; $display("FAIL bp_last2 got=%0b exp=1", l); end
    if (lat != 2) begin errors++; $display("FAIL bp_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) send(32'hE000_0000 + 32'(i), 1'b0, 3'd0);
    reset = 1'b1;
    #1;
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%0b exp=1", in_ready); end
    if (blk_valid !== 1'b0) begin errors++; $display("FAIL rmid_blk_valid got=%0b exp=0", blk_valid); end
    if (blk_last !== 1'b0) begin errors++; $display("FAIL rmid_blk_last got=%0b exp=0", blk_last); end
    if (blk_data !== 512'd0) begin errors++; $display("FAIL rmid_blk_data got=%h exp=0", blk_data); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    test_abc();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_nbytes = 3'd0; blk_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_56_bytes();
    test_64_bytes();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Upstream feeder for the SHA-256 compression core. Accepts an arbitrary-length message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit length. Emits complete 512-bit chunks over a valid/ready handshake. The mining controller drives each emitted chunk into the core's chunk input.

Parameters:
LEN_W, 64, width of internal bit-length counter (2..64); zero-extended into the 64-bit length field; wraps mod 2^LEN_W.

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  input word valid
in_ready  out  1  padder can accept a word this cycle
in_data  in  32  message word; byte 0 = bits [31:24]
in_last  in  1  word is the final word of the message
in_nbytes  in  3  valid bytes in last word (0..4, left-aligned); ignored unless in_last; values >4 treated as 4
blk_valid  out  1  blk_data holds a complete chunk
blk_ready  in  1  consumer accepts chunk
blk_data  out  512  chunk; word 0 = bits [511:480]
blk_last  out  1  chunk is the final (padded) chunk of the message

Behaviour:
- Reset values: in_ready=1, blk_valid=0, blk_last=0, blk_data=0, word index=0, length=0, state=FILL.
- Buffer is 16x32. It is cleared to zero on reset and on every accepted chunk (blk_valid & blk_ready), so zero fill is implicit.
- States: FILL, PAD, EMIT, LEN.
- FILL: in_ready=1. On in_valid:
  - not last: store in_data at idx; length += 32; idx++. If idx was 15, go EMIT (blk_last=0). blk_valid rises the cycle after the 16th word is accepted.
  - last: n=min(in_nbytes,4). Store in_data with bytes >=n zeroed. If n<4, insert 0x80 at byte n of the same word. length += 8n. Go PAD. nbytes=0 stores nothing at idx and defers 0x80 to PAD.
- PAD (1 cycle, in_ready=0):
  - If 0x80 is still pending (n=0 or n=4), write 0x80000000 at the next free word, or at idx when n=0.
  - Let p = index of the word holding 0x80.
  - p<=13: write {length} zero-extended into words 14,15; go EMIT with blk_last=1.
  - p>=14, or 0x80 does not fit (n=4 at idx 15): go EMIT with blk_last=0, then LEN.
- Latency: last word accepted cycle N, blk_valid at N+2.
- EMIT: in_ready=0; blk_valid=1.
  - blk_data and blk_last are held stable until blk_ready.
  - On handshake: clear buffer, idx=0. If the pending-extra flag is set, go LEN; else if blk_last, length=0 and go FILL; else go FILL.
- LEN (1 cycle): on the cleared buffer, write 0x80000000 at word 0 if still pending, and length in words 14,15. Go EMIT with blk_last=1.
- in_valid while in_ready=0 is ignored; the upstream source must hold its word.
- A new message may begin in the cycle after the final chunk handshake.
- Reset mid-operation: immediate abort; the partial chunk is discarded.

Optional Feature:
- SHA_PAD_BYTESWAP_EN defined: in_data is byte-reversed on capture (little-endian source, e.g. block header fields). in_nbytes then counts bytes from the swapped word's MSB.
- Undefined: words are captured as-is.
- Chunk layout and length field are identical in both builds.

Decomposition:
- sha256_pkg holds: localparams BLK_W=512, WORD_W=32, PAD_BYTE=8'h80; typedef enum for state {FILL,PAD,EMIT,LEN}; function bswap32.
- No sub-module needed; a single module. The byte mask/insert logic is a package function pad_word(data,n).

Test Plan:
- "abc": one word 0x61626300, last, nbytes=3 -> one chunk: word0=0x61626380, words1-14=0, word15=0x00000018, blk_last=1, blk_valid 2 cycles after accept.
- Empty message: in_last, nbytes=0 -> one chunk: word0=0x80000000, all others 0, blk_last=1.
- 56 bytes (14 words, last nbytes=4) -> chunk1 words0-13=data, word14=0x80000000, word15=0, blk_last=0; chunk2 words0-13=0, word15=0x000001C0, blk_last=1.
- 64 bytes (16 words, last nbytes=4) -> chunk1=data, blk_last=0; chunk2 word0=0x80000000, word15=0x00000200, blk_last=1.
- Backpressure: hold blk_ready=0 for 5 cycles on a full chunk -> blk_data and blk_valid stable, in_ready=0, no input consumed; accept on cycle 6, then in_ready=1 the next cycle.
- Reset asserted mid-FILL after 7 words -> outputs at reset values at once; next "abc" message yields the exact "abc" chunk.
